// File: rtl/voodoo_msg_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into 64 W/K round pairs,
// one pair per cycle, using a 16-word shifting window.
module voodoo_msg_schedule (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [511:0] block_in,
    input  logic         hold,
    output logic         en,
    output logic [6:0]   stage,
    output logic [31:0]  w,
    output logic [31:0]  k,
    output logic         busy,
    output logic         done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [31:0] K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] smallSigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] smallSigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_t              state_q, state_d;
    logic [6:0]          stage_q, stage_d;
    logic [31:0]         k_q, k_d;
    logic [15:0][31:0]   window_q, window_d;
    logic [31:0]         nextWord;
    logic [5:0]          nextIdx;

    // window_q[0] is always W[stage]; window_q[15] is W[stage+15]
    assign nextWord = smallSigma1(window_q[14]) + window_q[9]
                    + smallSigma0(window_q[1]) + window_q[0];
    assign nextIdx  = stage_q[5:0] + 6'd1;

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        k_d      = k_q;
        window_d = window_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    stage_d  = 7'd0;
                    k_d      = K_TABLE[0];
                    window_d = block_in;
                end
            end
            RUN: begin
                if (!hold) begin
                    if (stage_q == 7'd63) begin
                        state_d = IDLE;
                    end else begin
                        stage_d  = stage_q + 7'd1;
                        k_d      = K_TABLE[nextIdx];
                        window_d = {nextWord, window_q[15:1]};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            stage_q  <= 7'd0;
            k_q      <= 32'd0;
            window_q <= '0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            k_q      <= k_d;
            window_q <= window_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign en    = busy && !hold;
    assign done  = busy && (stage_q == 7'd63);
    assign stage = stage_q;
    assign w     = window_q[0];
    assign k     = k_q;

endmodule

// File: tb/tb_voodoo_msg_schedule.sv
// Scoreboard bench for voodoo_msg_schedule: a reference schedule model queues
// every expected round; a monitor pops one entry per enabled output cycle.
module tb_voodoo_msg_schedule;

    typedef struct {
        logic [6:0]  stage;
        logic [31:0] w;
        logic [31:0] k;
        logic        done;
    } exp_t;

    localparam logic [31:0] KREF [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         reset, start, hold;
    logic [511:0] block_in;
    logic         en, busy, done;
    logic [6:0]   stage;
    logic [31:0]  w, k;

    int   testsRun  = 0;
    int   failCount = 0;
    int   busyCount = 0;
    int   runLen    = 0;
    int   doneCount = 0;
    exp_t sbQ[$];

    voodoo_msg_schedule dut (
        .clk(clk), .reset(reset), .start(start), .block_in(block_in),
        .hold(hold), .en(en), .stage(stage), .w(w), .k(k),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] refSig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] refSig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic void pushRun(input logic [511:0] blk, input int nStages);
        logic [31:0] wArr [64];
        exp_t e;
        for (int t = 0; t < 16; t++) wArr[t] = blk[32*t +: 32];
        for (int t = 16; t < 64; t++)
            wArr[t] = refSig1(wArr[t-2]) + wArr[t-7] + refSig0(wArr[t-15]) + wArr[t-16];
        for (int t = 0; t < nStages; t++) begin
            e.stage = 7'(t);
            e.w     = wArr[t];
            e.k     = KREF[t];
            e.done  = (t == 63);
            sbQ.push_back(e);
        end
    endfunction

    function automatic logic [511:0] randBlock();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Monitor: every enabled cycle must match the oldest queued round
    always @(negedge clk) begin
        exp_t e;
        if (en === 1'b1) begin
            testsRun++;
            if (sbQ.size() == 0) begin
                failCount++;
                $display("FAIL sb_unexpected_en: got stage=%0d w=%h, expected no enabled output", stage, w);
            end else begin
                e = sbQ.pop_front();
                if (stage !== e.stage || w !== e.w || k !== e.k || done !== e.done || busy !== 1'b1) begin
                    failCount++;
                    $display("FAIL sb_round%0d: got stage=%0d w=%h k=%h done=%b busy=%b, expected stage=%0d w=%h k=%h done=%b busy=1",
                             e.stage, stage, w, k, done, busy, e.stage, e.w, e.k, e.done);
                end
            end
        end
        if (busy !== 1'b1) busyCount = 0;
        else busyCount++;
        if (done === 1'b1 && en === 1'b1) begin
            runLen = busyCount;
            doneCount++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [511:0] blk, input int nStages);
        @(posedge clk); #1;
        block_in = blk;
        start    = 1'b1;
        pushRun(blk, nStages);
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic waitStage(input logic [6:0] target);
        bit found = 1'b0;
        for (int n = 0; n < 300 && !found; n++) begin
            @(negedge clk);
            if (en === 1'b1 && stage === target) found = 1'b1;
        end
        testsRun++;
        if (!found) begin
            failCount++;
            $display("FAIL wait_stage%0d: got timeout, expected en with that stage", target);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [511:0] abcBlk, blkA, blkB, blkC, blkD, junk;

        reset = 1'b1; start = 1'b0; hold = 1'b0; block_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_en",    32'(en),    32'd0);
        checkOutput("rst_busy",  32'(busy),  32'd0);
        checkOutput("rst_done",  32'(done),  32'd0);
        checkOutput("rst_stage", 32'(stage), 32'd0);
        checkOutput("rst_w",     w,          32'd0);
        checkOutput("rst_k",     k,          32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        abcBlk = '0;
        abcBlk[31:0]    = 32'h61626380;
        abcBlk[511:480] = 32'h00000018;
        applyStimulus(abcBlk, 64);
        waitStage(7'd0);
        checkOutput("abc_w0",  w, 32'h61626380);
        checkOutput("abc_k0",  k, 32'h428a2f98);
        waitStage(7'd16);
        checkOutput("abc_w16", w, 32'h61626380);
        waitStage(7'd17);
        checkOutput("abc_w17", w, 32'h000f0000);
        waitStage(7'd63);
        checkOutput("abc_k63",   k,          32'hc67178f2);
        checkOutput("abc_done",  32'(done),  32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("abc_idle_busy",  32'(busy),  32'd0);
        checkOutput("abc_idle_en",    32'(en),    32'd0);
        checkOutput("abc_idle_stage", 32'(stage), 32'd63);
        checkOutput("abc_runlen",     runLen,     32'd64);

        blkA = randBlock();
        applyStimulus(blkA, 64);
        waitStage(7'd19);
        @(posedge clk); #1;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("hold20_en",    32'(en),    32'd0);
            checkOutput("hold20_stage", 32'(stage), 32'd20);
            @(posedge clk);
        end
        #1;
        hold = 1'b0;
        waitStage(7'd63);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("hold20_runlen", runLen, 32'd67);

        blkB = randBlock();
        junk = randBlock();
        applyStimulus(blkB, 64);
        waitStage(7'd4);
        @(posedge clk); #1;
        block_in = junk;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        waitStage(7'd62);
        @(posedge clk); #1;
        start = 1'b1;
        @(negedge clk);
        checkOutput("ign_done63", 32'(done), 32'd1);
        @(posedge clk); #1;
        blkC     = randBlock();
        block_in = blkC;
        pushRun(blkC, 41);
        @(negedge clk);
        checkOutput("ign_idle_en",    32'(en),    32'd0);
        checkOutput("ign_idle_busy",  32'(busy),  32'd0);
        checkOutput("ign_idle_done",  32'(done),  32'd0);
        checkOutput("ign_idle_k",     k,          32'hc67178f2);
        checkOutput("ign_donecount",  doneCount,  32'd3);
        @(posedge clk); #1;
        start = 1'b0;
        waitStage(7'd0);
        checkOutput("restart_w0", w, blkC[31:0]);

        waitStage(7'd39);
        @(posedge clk); #1;
        reset    = 1'b1;
        start    = 1'b1;
        block_in = junk;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_en",    32'(en),    32'd0);
        checkOutput("abort_busy",  32'(busy),  32'd0);
        checkOutput("abort_done",  32'(done),  32'd0);
        checkOutput("abort_stage", 32'(stage), 32'd0);
        checkOutput("abort_w",     w,          32'd0);
        checkOutput("abort_k",     k,          32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("abort_stays_idle", 32'(busy), 32'd0);
        checkOutput("abort_donecount",  doneCount, 32'd3);

        blkD = randBlock();
        @(posedge clk); #1;
        block_in = blkD;
        start    = 1'b1;
        hold     = 1'b1;
        pushRun(blkD, 64);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("sthold_en",    32'(en),    32'd0);
        checkOutput("sthold_busy",  32'(busy),  32'd1);
        checkOutput("sthold_stage", 32'(stage), 32'd0);
        checkOutput("sthold_w",     w,          blkD[31:0]);
        @(posedge clk); #1;
        hold = 1'b0;
        waitStage(7'd62);
        @(posedge clk); #1;
        hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("hold63_done",  32'(done),  32'd1);
            checkOutput("hold63_busy",  32'(busy),  32'd1);
            checkOutput("hold63_en",    32'(en),    32'd0);
            checkOutput("hold63_stage", 32'(stage), 32'd63);
            @(posedge clk);
        end
        #1;
        hold = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("hold63_idle_busy", 32'(busy), 32'd0);
        checkOutput("hold63_runlen",    runLen,    32'd67);
        checkOutput("final_donecount",  doneCount, 32'd4);

        repeat (3) @(posedge clk);
        checkOutput("sb_drained", sbQ.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/voodoo_msg_schedule.md
VOODOO_MSG_SCHEDULE -- requirements
Module: voodoo_msg_schedule

Interface
REQ-001 The block SHALL have one clock and a reset; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 start  input  1  request to begin one 64-round schedule; sampled only when busy=0.
REQ-005 block_in  input  512  message block, word i at bits [32i+31:32i], M0 at [31:0].
REQ-006 hold  input  1  freezes the schedule while high.
REQ-007 en  output  1  w/k/stage valid this cycle; drives the round fragment enable.
REQ-008 stage  output  7  round index 0..63 of current w/k.
REQ-009 w  output  32  schedule word W[stage].
REQ-010 k  output  32  SHA-256 round constant K[stage].
REQ-011 busy  output  1  schedule in progress.
REQ-012 done  output  1  one-cycle pulse coinciding with stage-63 output.

Function
REQ-013 States SHALL be IDLE and RUN only.
REQ-014 IDLE->RUN when start=1 and busy=0 at a rising edge; block_in SHALL be captured into a 16-word window at that edge.
REQ-015 Latency: start sampled at edge N -> en=1, stage=0, w=M0, k=0x428a2f98 during the cycle after edge N.
REQ-016 In RUN with hold=0, stage SHALL advance by 1 per cycle, w/k/stage all registered outputs.
REQ-017 For t<16, w SHALL be Mt; for t>=16, w SHALL be sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], modulo 2^32.
REQ-018 sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
REQ-019 Only a 16-word shifting window SHALL be stored; no 64-word array.
REQ-020 k SHALL come from a 64-entry constant table indexed by stage, standard FIPS 180-4 values.
REQ-021 busy SHALL be 1 from the stage-0 cycle through the stage-63 cycle inclusive, 0 otherwise.
REQ-022 done SHALL be 1 exactly in the stage-63 cycle; RUN->IDLE at the following edge.
REQ-023 start while busy=1, including the stage-63 cycle, SHALL be ignored; block_in not captured.
REQ-024 Earliest restart: start sampled at the first edge where busy=0; no back-to-back overlap.
REQ-025 hold=1 in RUN: stage, w, k, window, done SHALL keep their values; en SHALL be 0 while hold=1.
REQ-026 hold released: en returns to 1 with the same stage shown before hold; no round skipped or repeated.
REQ-027 hold=1 during stage 63: done stays high and busy stays 1 until hold drops and the cycle completes.
REQ-028 hold in IDLE SHALL have no effect; start+hold together in IDLE SHALL still capture, first output held until hold=0.
REQ-029 In IDLE, en=0, done=0; w, k, stage SHALL keep last values.
REQ-030 Arithmetic SHALL wrap modulo 2^32 with no carry-out or saturation.

Reset
REQ-031 reset=1 at any edge SHALL force IDLE, en=0, busy=0, done=0, stage=0, w=0, k=0, window cleared.
REQ-032 Reset mid-RUN SHALL abort with no further en pulses; start in the same cycle as reset SHALL be ignored.
REQ-033 First start after reset release SHALL behave per REQ-014/015.

Verification
REQ-034 "abc" padded block (M0=0x61626380, M15=0x00000018, others 0), start -> stage0 w=0x61626380 k=0x428a2f98; stage16 w=0x61626380; stage17 w=0x000F0000; stage63 k=0xc67178f2 with done=1.
REQ-035 Random blocks x1000 vs software model -> all 64 w/k match; en high exactly 64 cycles per start.
REQ-036 hold=1 for 3 cycles at stage 20 -> en=0 for 3 cycles, stage stays 20, then 21 follows; total 67 cycles start-to-done.
REQ-037 start pulsed at stages 5 and 63 -> ignored; single done; restart one cycle after done -> new stage 0.
REQ-038 reset asserted at stage 40 -> next cycle en=0, busy=0, stage=0, w=0; no done pulse.
